// File: rtl/dram_pkg.sv
// Shared constants and FSM state encoding for the dram_ctrl data-memory controller.
// The optional read-parity check is enabled by defining DRAM_PARITY_EN.
package dram_pkg;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_READ_LAT = 2;
    localparam int LAT_CNT_W    = 4;

    typedef logic [1:0] dram_state_t;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_RD_WAIT   = 2'd1;
    localparam logic [1:0] ST_WR_COMMIT = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

endpackage

// File: rtl/dram_array.sv
// Storage-only word array: one synchronous write port, one registered read port.
// Word width is chosen by the controller (data only, or data plus parity with DRAM_PARITY_EN).
module dram_array #(
    parameter int ADDR_W = 16,
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WORD_W-1:0] o_rd_data
);

    logic [WORD_W-1:0] r_mem [2**ADDR_W];
    logic [WORD_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dram_ctrl.sv
// Single-port data-memory controller: FSM, address latch, read-latency counter and re-arm logic.
// Define DRAM_PARITY_EN to store an even-parity bit per word and report read parity faults.
module dram_ctrl
    import dram_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int READ_LAT = DEF_READ_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_memory,
    input  logic              write_memory,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_write_DRAM,
    output logic [DATA_W-1:0] data_read_DRAM,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              parity_err
);

`ifdef DRAM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    dram_state_t          r_state;
    logic                 r_armed;
    logic [ADDR_W-1:0]    r_addr;
    logic [LAT_CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0]    r_data_read;
    logic                 r_mem_busy;
    logic                 r_mem_done;

    logic                 w_cmd;
    logic                 w_accept;
    logic                 w_we;
    logic [ADDR_W-1:0]    w_rd_addr;
    logic [WORD_W-1:0]    w_wr_word;
    logic [WORD_W-1:0]    w_rd_word;

    assign w_cmd    = read_memory | write_memory;
    assign w_accept = (r_state == ST_IDLE) && r_armed && w_cmd;
    assign w_we     = (r_state == ST_WR_COMMIT);

    // Read the incoming address on the acceptance edge so data is ready even with READ_LAT=1.
    assign w_rd_addr = (r_state == ST_IDLE) ? addr : r_addr;

`ifdef DRAM_PARITY_EN
    assign w_wr_word = {^data_write_DRAM, data_write_DRAM};
`else
    assign w_wr_word = data_write_DRAM;
`endif

    dram_array #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_array (
        .clk       (clk),
        .i_we      (w_we),
        .i_wr_addr (r_addr),
        .i_wr_data (w_wr_word),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_word)
    );

`ifdef DRAM_PARITY_EN
    logic r_is_read;
    logic r_parity_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_read    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_is_read <= !write_memory;
            end
            // X from an unwritten location also counts as a fault in simulation.
            r_parity_err <= (r_state == ST_DONE) && r_is_read && ((^w_rd_word) !== 1'b0);
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_armed     <= 1'b1;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_data_read <= '0;
            r_mem_busy  <= 1'b0;
            r_mem_done  <= 1'b0;
        end else begin
            r_mem_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr     <= addr;
                        r_mem_busy <= 1'b1;
                        r_armed    <= 1'b0;
                        if (write_memory) begin
                            r_state <= ST_WR_COMMIT;
                        end else begin
                            r_cnt   <= LAT_CNT_W'(READ_LAT - 1);
                            r_state <= ST_RD_WAIT;
                        end
                    end else if (!w_cmd) begin
                        r_armed <= 1'b1;
                    end
                end
                ST_RD_WAIT: begin
                    if (r_cnt == '0) begin
                        r_data_read <= w_rd_word[DATA_W-1:0];
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - LAT_CNT_W'(1);
                    end
                end
                ST_WR_COMMIT: begin
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_mem_done <= 1'b1;
                    r_mem_busy <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_read_DRAM = r_data_read;
    assign mem_busy       = r_mem_busy;
    assign mem_done       = r_mem_done;

endmodule
